// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 raster constants, sync polarity and colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int c_H_ACTIVE = 640;
    localparam int c_H_FP     = 16;
    localparam int c_H_SYNC   = 96;
    localparam int c_H_BP     = 48;
    localparam int c_H_TOTAL  = c_H_ACTIVE + c_H_FP + c_H_SYNC + c_H_BP;

    localparam int c_V_ACTIVE = 480;
    localparam int c_V_FP     = 10;
    localparam int c_V_SYNC   = 2;
    localparam int c_V_BP     = 33;
    localparam int c_V_TOTAL  = c_V_ACTIVE + c_V_FP + c_V_SYNC + c_V_BP;

    localparam logic c_SYNC_POL = 1'b0;

    localparam int         c_BAR_COUNT = 8;
    localparam logic [7:0] c_COMP_ON   = 8'hFF;
    localparam logic [7:0] c_COMP_OFF  = 8'h00;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black falls
    // out of the index bits: g = ~idx[2], r = ~idx[1], b = ~idx[0].
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        r = idx[1] ? c_COMP_OFF : c_COMP_ON;
        g = idx[2] ? c_COMP_OFF : c_COMP_ON;
        b = idx[0] ? c_COMP_OFF : c_COMP_ON;
        return {r, g, b};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : WIDTH-bit shift line of DEPTH clocks, DEPTH=0 passes through.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign o_dout = i_din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= '0;
                    end
                end else begin
                    r_stage[0] <= i_din;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_scan_timing
// Description : VGA raster generator; re-aligns renderer colour with syncs.
//               Optional VGA_TEST_PATTERN_EN adds test_mode colour bars.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scan_timing
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = c_H_ACTIVE,
    parameter int   H_FP     = c_H_FP,
    parameter int   H_SYNC   = c_H_SYNC,
    parameter int   H_BP     = c_H_BP,
    parameter int   V_ACTIVE = c_V_ACTIVE,
    parameter int   V_FP     = c_V_FP,
    parameter int   V_SYNC   = c_V_SYNC,
    parameter int   V_BP     = c_V_BP,
    parameter logic SYNC_POL = c_SYNC_POL,
    parameter int   PIPE_DLY = 1,
    parameter int   TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        de_early,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam int          c_H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [15:0] c_H_LAST   = 16'(c_H_TOT - 1);
    localparam logic [15:0] c_V_LAST   = 16'(c_V_TOT - 1);
    localparam logic [15:0] c_H_ACT    = 16'(H_ACTIVE);
    localparam logic [15:0] c_V_ACT    = 16'(V_ACTIVE);
    localparam logic [15:0] c_HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] c_VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] c_VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] c_DIV_LAST = 16'(TICK_DIV - 1);

    generate
        if (PIPE_DLY < 0 || PIPE_DLY > 7 || TICK_DIV < 1) begin : g_param_check
            $error("vga_scan_timing: PIPE_DLY must be 0..7 and TICK_DIV >= 1");
        end
    endgenerate

    logic [15:0] r_h_cnt;
    logic [15:0] r_v_cnt;
    logic [15:0] r_tick_div;
    logic        r_hs_raw;
    logic        r_vs_raw;
    logic        w_vblank_start;
    logic        w_hs_d;
    logic        w_vs_d;
    logic        w_de_d;
    logic [23:0] w_pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == c_H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? 16'd0 : r_v_cnt + 16'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 16'd1;
        end
    end

    assign w_vblank_start = (r_h_cnt == 16'd0) && (r_v_cnt == c_V_ACT);

    // Everything that must line up with x/y is registered from the counters
    // in one place, so x, y, de_early, raw syncs and frame_tick share a stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            de_early   <= 1'b0;
            r_hs_raw   <= 1'b0;
            r_vs_raw   <= 1'b0;
            frame_tick <= 1'b0;
            frame_cnt  <= '0;
            r_tick_div <= '0;
        end else begin
            x          <= r_h_cnt;
            y          <= r_v_cnt;
            de_early   <= (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
            r_hs_raw   <= (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
            r_vs_raw   <= (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
            frame_tick <= w_vblank_start && (r_tick_div == 16'd0);
            if (w_vblank_start) begin
                frame_cnt  <= frame_cnt + 16'd1;
                r_tick_div <= (r_tick_div == c_DIV_LAST) ? 16'd0 : r_tick_div + 16'd1;
            end
        end
    end

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DLY)
    ) u_ctrl_dly (
        .clk    (clk),
        .rst    (rst),
        .i_din  ({r_hs_raw, r_vs_raw, de_early}),
        .o_dout ({w_hs_d, w_vs_d, w_de_d})
    );

`ifdef VGA_TEST_PATTERN_EN
    localparam int c_BAR_W = H_ACTIVE / c_BAR_COUNT;

    logic [9:0] w_x_d;
    logic [2:0] w_bar_idx;

    vga_delay_line #(
        .WIDTH (10),
        .DEPTH (PIPE_DLY)
    ) u_x_dly (
        .clk    (clk),
        .rst    (rst),
        .i_din  (x[9:0]),
        .o_dout (w_x_d)
    );

    assign w_bar_idx = 3'(w_x_d / 10'(c_BAR_W));
    assign w_pix     = test_mode ? bar_rgb(w_bar_idx) : {r_in, g_in, b_in};
`else
    assign w_pix = {r_in, g_in, b_in};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_de <= 1'b0;
            vga_hs <= ~SYNC_POL;
            vga_vs <= ~SYNC_POL;
        end else begin
            {vga_r, vga_g, vga_b} <= w_de_d ? w_pix : 24'd0;
            vga_de <= w_de_d;
            vga_hs <= w_hs_d ? SYNC_POL : ~SYNC_POL;
            vga_vs <= w_vs_d ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scan_timing
// Description : Checks a 640x480 instance and a shrunken PIPE_DLY=3 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scan_timing;

    // Shrunken raster: 24 clocks per line, 12 lines, 288 clocks per frame.
    localparam int c_SH_TOT = 24;
    localparam int c_SV_TOT = 12;
    localparam int c_SFRAME = c_SH_TOT * c_SV_TOT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       r_rst   = 1'b1;
    logic       r_rst_s = 1'b1;
    logic       r_tm    = 1'b0;
    logic [7:0] r_rd = '0, r_gd = '0, r_bd = '0;
    logic [7:0] r_rs = '0, r_gs = '0, r_bs = '0;

    logic [15:0] w_xd, w_yd, w_fcd, w_xs, w_ys, w_fcs;
    logic        w_ded, w_vded, w_hsd, w_vsd, w_ftd;
    logic        w_des, w_vdes, w_hss, w_vss, w_fts;
    logic [7:0]  w_vrd, w_vgd, w_vbd, w_vrs, w_vgs, w_vbs;

    vga_scan_timing u_dut (
        .clk        (clk),
        .rst        (r_rst),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode  (r_tm),
`endif
        .x          (w_xd),
        .y          (w_yd),
        .de_early   (w_ded),
        .r_in       (r_rd),
        .g_in       (r_gd),
        .b_in       (r_bd),
        .vga_r      (w_vrd),
        .vga_g      (w_vgd),
        .vga_b      (w_vbd),
        .vga_hs     (w_hsd),
        .vga_vs     (w_vsd),
        .vga_de     (w_vded),
        .frame_tick (w_ftd),
        .frame_cnt  (w_fcd)
    );

    vga_scan_timing #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .PIPE_DLY (3),  .TICK_DIV (3)
    ) u_small (
        .clk        (clk),
        .rst        (r_rst_s),
`ifdef VGA_TEST_PATTERN_EN
        .test_mode  (1'b0),
`endif
        .x          (w_xs),
        .y          (w_ys),
        .de_early   (w_des),
        .r_in       (r_rs),
        .g_in       (r_gs),
        .b_in       (r_bs),
        .vga_r      (w_vrs),
        .vga_g      (w_vgs),
        .vga_b      (w_vbs),
        .vga_hs     (w_hss),
        .vga_vs     (w_vss),
        .vga_de     (w_vdes),
        .frame_tick (w_fts),
        .frame_cnt  (w_fcs)
    );

    int errors = 0;
    int checks = 0;
    int kd = 0;
    int ks = 0;
    logic [15:0] hxd [8];
    logic [15:0] hyd [8];
    logic [15:0] hxs [8];
    logic [15:0] hys [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (kd=%0d ks=%0d)", name, act, exp, kd, ks);
        end
    endtask

    // One clock; afterwards the renderer models present colour for the
    // pixel PIPE_DLY clocks behind the current x/y of each instance.
    task automatic step();
        @(posedge clk);
        #1;
        kd = r_rst   ? 0 : kd + 1;
        ks = r_rst_s ? 0 : ks + 1;
        for (int i = 7; i > 0; i--) begin
            hxd[i] = hxd[i-1]; hyd[i] = hyd[i-1];
            hxs[i] = hxs[i-1]; hys[i] = hys[i-1];
        end
        hxd[0] = w_xd; hyd[0] = w_yd;
        hxs[0] = w_xs; hys[0] = w_ys;
        r_rd = hxd[1][7:0]; r_gd = hyd[1][7:0]; r_bd = 8'h55;
        r_rs = hxs[3][7:0]; r_gs = hys[3][7:0]; r_bs = 8'h55;
    endtask

    typedef struct {
        int          k;
        logic [15:0] x;
        logic [15:0] y;
        logic        de_e;
        logic        vde;
        logic        vhs;
        logic [7:0]  vr;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int ti;
        int hs_fall1, hs_rise1, hs_fall2, vs_fall1, vs_rise1;
        int ticks_d, ticks_s;
        logic prev_hs, prev_vs;
        int s, sx, sy;
        logic sde;
        logic [24:0] exp_pix;
        logic        exp_tick;

        // Default instance: x(k)=(k-1)%800, pins at k show the stage of k-2.
        tbl[0]  = '{1,   0,   0, 1, 0, 1, 8'd0};
        tbl[1]  = '{2,   1,   0, 1, 0, 1, 8'd0};
        tbl[2]  = '{3,   2,   0, 1, 1, 1, 8'd0};
        tbl[3]  = '{100, 99,  0, 1, 1, 1, 8'd97};
        tbl[4]  = '{300, 299, 0, 1, 1, 1, 8'd41};
        tbl[5]  = '{640, 639, 0, 1, 1, 1, 8'd125};
        tbl[6]  = '{641, 640, 0, 0, 1, 1, 8'd126};
        tbl[7]  = '{642, 641, 0, 0, 1, 1, 8'd127};
        tbl[8]  = '{643, 642, 0, 0, 0, 1, 8'd0};
        tbl[9]  = '{658, 657, 0, 0, 0, 1, 8'd0};
        tbl[10] = '{659, 658, 0, 0, 0, 0, 8'd0};
        tbl[11] = '{754, 753, 0, 0, 0, 0, 8'd0};
        tbl[12] = '{755, 754, 0, 0, 0, 1, 8'd0};
        tbl[13] = '{800, 799, 0, 0, 0, 1, 8'd0};
        tbl[14] = '{801, 0,   1, 1, 0, 1, 8'd0};
        tbl[15] = '{803, 2,   1, 1, 1, 1, 8'd0};

        for (int i = 0; i < 8; i++) begin
            hxd[i] = '0; hyd[i] = '0; hxs[i] = '0; hys[i] = '0;
        end

        for (int i = 0; i < 3; i++) step();
        check("rst_x",       32'(w_xd), 0);
        check("rst_y",       32'(w_yd), 0);
        check("rst_de_early", 32'(w_ded), 0);
        check("rst_vga_de",  32'(w_vded), 0);
        check("rst_vga_hs",  32'(w_hsd), 1);
        check("rst_vga_vs",  32'(w_vsd), 1);
        check("rst_rgb",     32'({w_vrd, w_vgd, w_vbd}), 0);
        check("rst_tick",    32'(w_ftd), 0);
        check("rst_fcnt",    32'(w_fcd), 0);
        check("rst_s_fcnt",  32'(w_fcs), 0);

        r_rst = 1'b0;
        r_rst_s = 1'b0;
        ti = 0;
        hs_fall1 = -1; hs_rise1 = -1; hs_fall2 = -1; vs_fall1 = -1; vs_rise1 = -1;
        ticks_d = 0; ticks_s = 0;
        prev_hs = w_hsd; prev_vs = w_vss;

        for (int n = 0; n < 2200; n++) begin
            step();
            if (ti < 16 && kd == tbl[ti].k) begin
                check($sformatf("tbl%0d_x", ti),  32'(w_xd),   32'(tbl[ti].x));
                check($sformatf("tbl%0d_y", ti),  32'(w_yd),   32'(tbl[ti].y));
                check($sformatf("tbl%0d_de", ti), 32'(w_ded),  32'(tbl[ti].de_e));
                check($sformatf("tbl%0d_vde", ti), 32'(w_vded), 32'(tbl[ti].vde));
                check($sformatf("tbl%0d_hs", ti), 32'(w_hsd),  32'(tbl[ti].vhs));
                check($sformatf("tbl%0d_r", ti),  32'(w_vrd),  32'(tbl[ti].vr));
                ti++;
            end
            if (prev_hs && !w_hsd) begin
                if (hs_fall1 < 0) hs_fall1 = kd; else if (hs_fall2 < 0) hs_fall2 = kd;
            end
            if (!prev_hs && w_hsd && hs_rise1 < 0) hs_rise1 = kd;
            prev_hs = w_hsd;
            if (w_ftd) ticks_d++;

            // Small instance: pins at ks carry the x/y stage of ks-4.
            s = ks - 4;
            if (s >= 1) begin
                sx = (s - 1) % c_SH_TOT;
                sy = ((s - 1) / c_SH_TOT) % c_SV_TOT;
                sde = (sx < 16) && (sy < 8);
                exp_pix = sde ? {1'b1, 8'(sx), 8'(sy), 8'h55} : 25'd0;
            end else begin
                exp_pix = 25'd0;
            end
            check("small_pix", 32'({w_vdes, w_vrs, w_vgs, w_vbs}), 32'(exp_pix));
            exp_tick = ((ks - 1) % c_SFRAME == 8 * c_SH_TOT) && (((ks - 1) / c_SFRAME) % 3 == 0);
            check("small_tick", 32'(w_fts), 32'(exp_tick));
            if (w_fts) begin
                ticks_s++;
                check("small_tick_xy", 32'({w_xs, w_ys}), 32'({16'd0, 16'd8}));
            end
            if (prev_vs && !w_vss && vs_fall1 < 0) vs_fall1 = ks;
            if (!prev_vs && w_vss && vs_rise1 < 0) vs_rise1 = ks;
            prev_vs = w_vss;
        end

        check("tbl_reached",  32'(ti), 16);
        check("hs_first_fall", 32'(hs_fall1), 659);
        check("hs_width",     32'(hs_rise1 - hs_fall1), 96);
        check("hs_period",    32'(hs_fall2 - hs_fall1), 800);
        check("def_no_tick",  32'(ticks_d), 0);
        check("vs_first_fall", 32'(vs_fall1), 221);
        check("vs_width",     32'(vs_rise1 - vs_fall1), 48);
        check("small_ticks",  32'(ticks_s), 3);
        check("small_fcnt",   32'(w_fcs), 7);

        // Mid-frame reset of the small instance at x=10, y=5.
        for (int n = 0; n < c_SFRAME + 2; n++) begin
            if ((ks - 1) % c_SFRAME == 5 * c_SH_TOT + 10) break;
            step();
        end
        check("pre_rst_xy", 32'({w_xs, w_ys}), 32'({16'd10, 16'd5}));
        r_rst_s = 1'b1;
        step();
        check("mid_rst_xy", 32'({w_xs, w_ys}), 0);
        r_rst_s = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (i == 1) check("post_rst_xy", 32'({w_xs, w_ys}), 0);
            check($sformatf("refill%0d", i),
                  32'({w_vdes, w_hss, w_vss, w_vrs, w_vbs}), 32'({1'b0, 1'b1, 1'b1, 16'd0}));
        end
        step();
        check("refilled_pix", 32'({w_vdes, w_vrs, w_vbs}), 32'({1'b1, 8'd0, 8'h55}));
        step();
        check("refilled_r1", 32'(w_vrs), 1);

`ifdef VGA_TEST_PATTERN_EN
        begin
            logic [23:0] bars [8];
            bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
            bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
            r_rst = 1'b1;
            r_tm  = 1'b1;
            step();
            r_rst = 1'b0;
            for (int n = 0; n < 645; n++) begin
                step();
                if (kd >= 3 && kd <= 642)
                    check($sformatf("bar_x%0d", kd - 3), 32'({w_vrd, w_vgd, w_vbd}),
                          32'(bars[(kd - 3) / 80]));
            end
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_scan_timing.md
Name: vga_scan_timing

Overview:
- Upstream/downstream wrapper around the game renderer. Generates 640x480@60 raster scan coordinates x/y for the renderer.
- Accepts the renderer's r/g/b back after a fixed pipeline delay. Re-aligns hsync/vsync/de with that colour and drives the registered VGA pins.
- Also emits a once-per-N-frames update tick used as the game/button update clock-enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch; H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch; V_TOTAL = sum = 525
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIPE_DLY, 1, clocks from x/y valid to rgb_in valid (range 0..7)
- TICK_DIV, 1, frame_tick asserted once every TICK_DIV frames (>=1)

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst  in  1  synchronous, active-high reset
- x  out  16  current horizontal scan position, 0..H_TOTAL-1
- y  out  16  current vertical scan position, 0..V_TOTAL-1
- de_early  out  1  x<H_ACTIVE && y<V_ACTIVE, aligned with x/y
- r_in, g_in, b_in  in  8 each  renderer colour, valid PIPE_DLY clocks after x/y
- vga_r, vga_g, vga_b  out  8 each  registered pixel colour
- vga_hs, vga_vs  out  1 each  registered syncs
- vga_de  out  1  registered data-enable aligned with vga_rgb
- frame_tick  out  1  single-cycle pulse at start of vertical blanking
- frame_cnt  out  16  frames since reset, wraps at 65535->0

Behaviour:
- Reset: h_cnt=v_cnt=0, x=y=0, de_early=0, vga_rgb=0, vga_de=0, vga_hs=vga_vs=~SYNC_POL (inactive), frame_tick=0, frame_cnt=0, tick divider=0, delay line cleared.
- Reset asserted mid-frame: the cycle after rst deasserts presents x=0,y=0. Outputs stay at reset values until the delay line refills, i.e. PIPE_DLY+1 clocks.
- Scan counters: h_cnt increments every clk. At H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. At h_cnt=H_TOTAL-1 with v_cnt=V_TOTAL-1, both wrap to 0.
- x=h_cnt and y=v_cnt are registered, so they are valid in the same cycle as de_early.
- Sync generation, from counters at the x/y stage:
  - hs_raw active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- Alignment:
  - hs/vs/de are delayed PIPE_DLY clocks through a shift line, then registered together with rgb_in.
  - Total latency from x/y to the vga_* pins is PIPE_DLY+1 clocks for every signal.
- Blanking: vga_rgb=0 whenever the delayed de is 0. rgb_in is ignored during blanking.
- frame_tick:
  - Asserted for exactly one clk when h_cnt=0 and v_cnt=V_ACTIVE, gated by the divider.
  - The divider counts 0..TICK_DIV-1; the tick fires when the divider is 0, and the divider advances each frame.
  - frame_cnt increments on the same cycle as every vertical-blank start, independent of the divider.
- Width rules: all counters are 16 bit. Comparisons are unsigned; no negative arithmetic.
- Parameter sanity: elaboration error if PIPE_DLY>7 or TICK_DIV==0.

Optional Feature:
- VGA_TEST_PATTERN_EN: when defined, adds input test_mode (1 bit).
  - With test_mode=1, rgb_in is ignored.
  - The output stage uses 8 vertical colour bars, each H_ACTIVE/8 = 80 px wide, derived from the delayed x.
  - Bar order: white, yellow, cyan, green, magenta, red, blue, black; each component is 0x00 or 0xFF.
  - The bars have the same latency as normal video.
- Without the macro: no port, no mux; the output is always rgb_in.

Decomposition:
- Package vga_timing_pkg:
  - 640x480@60 default constants (H_/V_ active, porch and sync values, totals).
  - Sync polarity constant.
  - Colour-bar constants.
- Sub-module vga_delay_line, parameterised WIDTH and DEPTH (DEPTH=0 means pass-through), with synchronous clear on rst.
  - Instantiated once for {hs, vs, de}.
  - When the test pattern is enabled, also instantiated once for x[9:0].

Test Plan:
- Reset, release, run 800*525 clocks -> x wraps at 799 and y wraps at 524; exactly one frame_tick, at x=0,y=480; frame_cnt=1.
- Count vga_hs low-pulse widths -> 96 clocks each, 800-clock period. vga_vs low for exactly 2 lines (1600 clocks), starting at line 490+latency.
- PIPE_DLY=3, drive rgb_in = {x[7:0], y[7:0], 0x55} from a 3-stage model -> vga_r equals the x of the pixel 4 clocks earlier; vga_rgb=0 whenever vga_de=0.
- TICK_DIV=3, run 7 frames -> frame_tick on frames 0, 3, 6 only; frame_cnt=7.
- Assert rst for 1 clk at x=300,y=200 -> next cycle x=0,y=0; vga_hs/vs inactive and vga_rgb=0 for PIPE_DLY+1 clocks, then normal.
- VGA_TEST_PATTERN_EN with test_mode=1 -> line 0 x=0..79 outputs FFFFFF, x=80..159 outputs FFFF00, ..., x=560..639 outputs 000000.
